bram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 256x8 block RAM (blk_mem_gen_0). It accepts read/write requests from two clients over valid/ready handshakes and grants one per cycle. It drives the BRAM's port A through registered outputs and routes each read result back to the client that issued it. It sits between the BRAM and its users, for example a capture writer and a readout engine, so neither client touches the BRAM pins directly.

---
 rtl/bram_ctrl_pkg.sv | 16 +
 rtl/bram_req_arb.sv | 50 +++++
 rtl/bram_port_arbiter.sv | 92 +++++++++
 tb/tb_bram_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the block-RAM port arbiter: default widths,
// requester count and the read-tag record carried alongside BRAM reads.
package bram_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_REQ    = 2;
  localparam int ID_W       = $clog2(NUM_REQ);

  // One in-flight read: marks that a response is due and who gets it
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bram_req_arb.sv
// Two-requester grant logic. Produces a one-hot grant from the request
// vector, combinationally. Optional macro BRAM_ARB_RR_EN selects
// round-robin between contending requesters; otherwise requester 0 wins.
module bram_req_arb
  import bram_ctrl_pkg::*;
(
  input  logic               clka,
  input  logic               rsta,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

`ifdef BRAM_ARB_RR_EN
  logic rr_ptr;

  // Pointer moves to the other requester after every contested grant
  always_ff @(posedge clka) begin
    if (rsta) begin
      rr_ptr <= 1'b0;
    end else if (&req) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  // Lone requester always wins; contention resolved by the pointer
  always_comb begin
    gnt = '0;
    if (!rsta) begin
      if (&req) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end
`else
  // Fixed priority: requester 0 beats requester 1
  always_comb begin
    gnt = '0;
    if (!rsta) begin
      if (req[0]) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbiter/sequencer in front of a single-port block RAM. Grants one client
// request per cycle, drives the BRAM port A from registers and steers each
// read result back to its issuer via a tag pipeline matched to the BRAM
// read latency. Optional macro BRAM_ARB_RR_EN: round-robin arbitration.
module bram_port_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clka,
  input  logic                      rsta,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      ena,
  output logic                      wea,
  output logic [ADDR_W-1:0]         addra,
  output logic [DATA_W-1:0]         dina,
  input  logic [DATA_W-1:0]         douta
);

  logic [NUM_REQ-1:0] gnt;
  logic               acc;
  logic [ID_W-1:0]    win_id;

  // Tag stage k is valid in the cycle k+1 after acceptance; the last stage
  // lines up with the BRAM data appearing on douta.
  tag_t tag_p [RD_LATENCY+1];

  bram_req_arb u_arb (
    .clka (clka),
    .rsta (rsta),
    .req  (req_valid),
    .gnt  (gnt)
  );

  // A grant is only ever issued to a valid requester, so grant == accept
  assign req_ready = gnt;
  assign acc       = |gnt;
  assign win_id    = gnt[1];

  // ---- stage p0: winner's request onto the BRAM pins ----
  // Address/data hold when idle so the BRAM inputs stay quiet
  always_ff @(posedge clka) begin
    if (rsta) begin
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      ena <= acc;
      wea <= acc & req_we[win_id];
      if (acc) begin
        addra <= req_addr[win_id*ADDR_W +: ADDR_W];
        dina  <= req_wdata[win_id*DATA_W +: DATA_W];
      end
    end
  end

  // ---- stages p0..pN: read tags follow the access through the BRAM ----
  // Reset flushes every stage so in-flight reads never respond
  always_ff @(posedge clka) begin
    if (rsta) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        tag_p[i] <= '0;
      end
    end else begin
      tag_p[0].valid <= acc & ~req_we[win_id];
      tag_p[0].id    <= win_id;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  // ---- response: emerging tag qualifies douta for its requester ----
  always_comb begin
    rsp_valid = '0;
    if (tag_p[RD_LATENCY].valid && !rsta) begin
      rsp_valid[tag_p[RD_LATENCY].id] = 1'b1;
    end
  end

  assign rsp_data = douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised self-checking bench for bram_port_arbiter. Contains a simple
// BRAM model and a transaction-level reference: grants from the
// arbitration rules, expected pins, and expected responses keyed by cycle.
module tb_bram_port_arbiter #(
  parameter int RD_LAT = 1
);

`ifdef BRAM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clka;
  logic        rsta;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        ena;
  logic        wea;
  logic [7:0]  addra;
  logic [7:0]  dina;
  logic [7:0]  douta;

  bram_port_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clka      (clka),
    .rsta      (rsta),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Single-port BRAM model, read-first, optional output register
  logic [7:0] mem [256];
  logic [7:0] q_p0, q_p1;
  always @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      q_p0 <= mem[addra];
    end
    q_p1 <= q_p0;
  end
  assign douta = (RD_LAT == 1) ? q_p0 : q_p1;

  // Reference state
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  bit         pins_known = 1'b0;
  bit         rr_ptr = 1'b0;
  logic [7:0] refmem [256];
  logic       exp_ena, exp_wea;
  logic [7:0] exp_addra, exp_dina;
  int         exp_rid [int];
  logic [7:0] exp_rd  [int];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check, advance the model
  task automatic step(input bit r, input logic [1:0] v, input logic [1:0] we,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1);
    logic [1:0] g;
    logic [1:0] exp_v;
    int         id;
    logic [7:0] a, d;
    @(negedge clka);
    rsta      = r;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    g = 2'b00;
    if (!r) begin
      if (v == 2'b01) g = 2'b01;
      else if (v == 2'b10) g = 2'b10;
      else if (v == 2'b11) begin
        g = (RR_MODE && rr_ptr) ? 2'b10 : 2'b01;
        if (RR_MODE) rr_ptr = ~rr_ptr;
      end
    end
    check_eq("req_ready", 32'(req_ready), 32'(g));
    if (pins_known) begin
      check_eq("ena", 32'(ena), 32'(exp_ena));
      check_eq("wea", 32'(wea), 32'(exp_wea));
      check_eq("addra", 32'(addra), 32'(exp_addra));
      check_eq("dina", 32'(dina), 32'(exp_dina));
    end
    exp_v = 2'b00;
    if (!r && exp_rid.exists(cyc)) exp_v = (exp_rid[cyc] == 1) ? 2'b10 : 2'b01;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v != 2'b00) check_eq("rsp_data", 32'(rsp_data), 32'(exp_rd[cyc]));
    if (exp_rid.exists(cyc)) begin
      exp_rid.delete(cyc);
      exp_rd.delete(cyc);
    end
    if (r) begin
      pins_known = 1'b1;
      exp_ena = 1'b0; exp_wea = 1'b0; exp_addra = 8'h00; exp_dina = 8'h00;
      exp_rid.delete();
      exp_rd.delete();
      rr_ptr = 1'b0;
    end else if (g != 2'b00) begin
      id = g[1] ? 1 : 0;
      a  = g[1] ? a1 : a0;
      d  = g[1] ? d1 : d0;
      exp_ena = 1'b1; exp_wea = we[id]; exp_addra = a; exp_dina = d;
      if (we[id]) refmem[a] = d;
      else begin
        exp_rid[cyc+1+RD_LAT] = id;
        exp_rd[cyc+1+RD_LAT]  = refmem[a];
      end
    end else begin
      exp_ena = 1'b0; exp_wea = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    logic [1:0] rv, rwe;
    logic [7:0] ra0, ra1;
    rsta = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step(1'b1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b1, 2'b11, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(1);

    // Preload every location with its own address through the arbiter
    for (int i = 0; i < 256; i++) step(1'b0, 2'b01, 2'b01, 8'(i), 8'h00, 8'(i), 8'h00);
    idle(2);

    // Requester 0 write then read of 0x10
    step(1'b0, 2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
    step(1'b0, 2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    idle(4);

    // Both requesters reading continuously
    for (int i = 0; i < 8; i++) step(1'b0, 2'b11, 2'b00, 8'(i), 8'(7 - i), 8'h00, 8'h00);
    idle(4);

    // Requester 1 back-to-back reads
    for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 2'b00, 8'h00, 8'(8'h20 + i), 8'h00, 8'h00);
    idle(4);

    // Top address write/read
    step(1'b0, 2'b10, 2'b10, 8'h00, 8'hFF, 8'h00, 8'h3C);
    step(1'b0, 2'b10, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00);
    idle(4);

    // Read, then reset the cycle after acceptance
    step(1'b0, 2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00);
    step(1'b1, 2'b11, 2'b00, 8'h05, 8'h06, 8'h00, 8'h00);
    idle(4);

    // Randomised traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      rv  = 2'($urandom);
      rwe = 2'($urandom);
      ra0 = 8'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
      ra1 = 8'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
      step($urandom_range(0, 99) == 0, rv, rwe, ra0, ra1, 8'($urandom), 8'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
